gen_pattern_checker: RTL and testbench
======================================

# gen_pattern_checker

Consumer-side checker for the three-lane constant word pattern driven by the generate-block test designs: lane 1 = 4, lane 2 = 2, lane 3 = 7, 3 bits each. It samples the lanes on a valid strobe and compares each lane against a parameterized expectation using a genvar-generated per-lane comparator. A small FSM declares PASS after a run of consecutive matching samples, or FAIL on the first mismatch. It also records which lanes and how many bits were wrong. It sits beside pattern-producing test modules as the self-checking end of the frontend generate/initial/always regression designs.

## Interface
Parameters:
- EXP1, 3'd4, expected lane 1 word
- EXP2, 3'd2, expected lane 2 word
- EXP3, 3'd7, expected lane 3 word
- LANE3_EN, 1, generate-if: 0 removes the lane 3 comparator (lane treated as always matching)
- PASS_COUNT, 8, consecutive matching samples required for PASS; legal range 1 .. 2^CNT_W-1
- CNT_W, 8, width of match_cnt

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- start  in  1  begin or restart a check run (single-cycle pulse)
- in_valid  in  1  word1..word3 valid this cycle
- word1  in  3  lane 1 sample
- word2  in  3  lane 2 sample
- word3  in  3  lane 3 sample (ignored when LANE3_EN=0)
- busy  out  1  high while in CHECK
- pass  out  1  high while in PASS
- fail  out  1  high while in FAIL
- err_lanes  out  3  lane mismatch mask of the failing sample, bit i = lane i+1
- err_bits  out  4  total differing bits in the failing sample, range 0..9
- match_cnt  out  CNT_W  consecutive matching samples in the current run

## Operation
- FSM states: IDLE, CHECK, PASS, FAIL.
- Sampling: a sample is taken when in_valid=1 and start=0 and the state is CHECK.
- IDLE:
  - start -> CHECK; match_cnt, err_lanes and err_bits are cleared.
  - in_valid is ignored.
- CHECK, matching sample: all enabled lanes equal their EXPn.
  - match_cnt increments.
  - If the incremented value equals PASS_COUNT, go to PASS; otherwise stay in CHECK.
- CHECK, mismatching sample: go to FAIL.
  - err_lanes <= per-lane mismatch mask.
  - err_bits <= sum of popcount(word_i ^ EXP_i) over enabled lanes.
  - match_cnt holds its value.
- CHECK, in_valid=0: no change.
- PASS and FAIL are sticky:
  - in_valid is ignored.
  - Outputs hold until start or reset.
  - start returns the FSM to CHECK with counters and error fields cleared.
- start in CHECK: restarts the run, clearing match_cnt and the error fields.
  - start has priority over a same-cycle in_valid; that sample is discarded.
- LANE3_EN=0:
  - The lane 3 comparator is not generated.
  - err_lanes[2] is tied to 0 and lane 3 contributes 0 to err_bits.
- Width rules:
  - match_cnt never wraps, because the FSM leaves CHECK when match_cnt reaches PASS_COUNT.
  - err_bits is a 4-bit unsigned sum of three zero-extended 2-bit popcounts.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, pass=0, fail=0, err_lanes=0, err_bits=0, match_cnt=0.
- Reset asserted mid-run aborts immediately. After release the block stays in IDLE until start.
- All outputs are registered. A sample at edge N is reflected in the outputs after edge N; there are no combinational input-to-output paths.
- start at edge N gives busy=1 from edge N. The first sample that can be taken is at edge N+1.
- With in_valid held high from edge N+1, pass=1 and busy=0 after edge N+PASS_COUNT.
- A mismatch at edge M gives fail=1 after edge M, with err_lanes and err_bits valid in the same cycle.

## Structure
- Package gen_chk_pkg holds:
  - typedef enum logic [1:0] chk_state_t {IDLE, CHECK, PASS, FAIL};
  - the default expectation constants EXP1_DEF=3'd4, EXP2_DEF=3'd2, EXP3_DEF=3'd7;
  - LANES=3.
- Sub-module gen_lane_cmp: a 3-bit data input and 3-bit expectation parameter, producing the outputs mismatch (1 bit) and nbits (2-bit popcount of the XOR).
  - Instantiated in a genvar loop over the lanes.
  - Lane 3 is instantiated inside a generate-if on LANE3_EN.
- The top level contains only the FSM, the counter and the error capture registers.

## Test plan
- Reset, start, then 8 valid samples (4,2,7) -> busy high for 8 cycles; pass=1 after the 8th sample; match_cnt=8; fail=0; err_lanes=0.
- Start, 3 good samples, then (4,3,7) -> fail=1 after the 4th sample; err_lanes=3'b010; err_bits=1; match_cnt=3.
- Start, first sample (0,0,0) -> fail=1; err_lanes=3'b111; err_bits=5 (1+1+3).
- LANE3_EN=0, 8 samples (4,2,0) -> pass=1; err_lanes[2]=0 throughout.
- Start with in_valid=1 in the same cycle, then 5 good samples; start+bad-sample in one cycle; then 8 good samples -> the bad sample is discarded; match_cnt restarts at 0; pass=1 after the final 8th sample.
- Assert rst_n low mid-CHECK with match_cnt=5 -> all outputs 0 immediately; 10 valid samples after release leave the block in IDLE with match_cnt=0.

Source files
------------

// File: rtl/gen_chk_pkg.sv
// gen_chk_pkg: shared state type and default lane expectations for the pattern checker
package gen_chk_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, PASS, FAIL} chk_state_t;

    localparam logic [2:0] EXP1_DEF = 3'd4;
    localparam logic [2:0] EXP2_DEF = 3'd2;
    localparam logic [2:0] EXP3_DEF = 3'd7;
    localparam int LANES = 3;

endpackage

// File: rtl/gen_lane_cmp.sv
// gen_lane_cmp: compares one 3-bit lane against a fixed expectation and counts differing bits
module gen_lane_cmp #(
    parameter logic [2:0] EXP = 3'd0
) (
    input  logic [2:0] data,
    output logic       mismatch,
    output logic [1:0] nbits
);

    logic [2:0] diff;

    assign diff     = data ^ EXP;
    assign mismatch = |diff;
    assign nbits    = {1'b0, diff[0]} + {1'b0, diff[1]} + {1'b0, diff[2]};

endmodule

// File: rtl/gen_pattern_checker.sv
// gen_pattern_checker: checks a three-lane constant word pattern, declaring PASS after a run
// of matching samples or FAIL on the first mismatch with the failing lanes and bit count.
module gen_pattern_checker
    import gen_chk_pkg::*;
#(
    parameter logic [2:0] EXP1       = EXP1_DEF,
    parameter logic [2:0] EXP2       = EXP2_DEF,
    parameter logic [2:0] EXP3       = EXP3_DEF,
    parameter bit         LANE3_EN   = 1'b1,
    parameter int         PASS_COUNT = 8,
    parameter int         CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [2:0]       word1,
    input  logic [2:0]       word2,
    input  logic [2:0]       word3,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       err_lanes,
    output logic [3:0]       err_bits,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [3*LANES-1:0] EXP_ALL = {EXP3, EXP2, EXP1};
    localparam logic [CNT_W-1:0]   PASS_N  = CNT_W'(PASS_COUNT);

    chk_state_t             state;
    logic [3*LANES-1:0]     words;
    logic [LANES-1:0]       mis;
    logic [2*LANES-1:0]     nb;
    logic [3:0]             err_sum;
    logic [CNT_W-1:0]       cnt_next;

    assign words = {word3, word2, word1};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i < LANES - 1 || LANE3_EN) begin : g_cmp
            gen_lane_cmp #(.EXP(EXP_ALL[3*i +: 3])) u_cmp (
                .data    (words[3*i +: 3]),
                .mismatch(mis[i]),
                .nbits   (nb[2*i +: 2])
            );
        end else begin : g_tie
            // a disabled lane always matches and contributes no error bits
            logic unused_lane;
            assign unused_lane    = ^words[3*i +: 3];
            assign mis[i]         = 1'b0;
            assign nb[2*i +: 2]   = 2'b00;
        end
    end

    assign err_sum  = {2'b00, nb[1:0]} + {2'b00, nb[3:2]} + {2'b00, nb[5:4]};
    assign cnt_next = match_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            err_lanes <= '0;
            err_bits  <= '0;
            match_cnt <= '0;
        end else if (start) begin
            // start wins over any same-cycle sample, from every state
            state     <= CHECK;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail      <= 1'b0;
            err_lanes <= '0;
            err_bits  <= '0;
            match_cnt <= '0;
        end else if (state == CHECK && in_valid) begin
            if (!(|mis)) begin
                match_cnt <= cnt_next;
                if (cnt_next == PASS_N) begin
                    state <= PASS;
                    busy  <= 1'b0;
                    pass  <= 1'b1;
                end
            end else begin
                state     <= FAIL;
                busy      <= 1'b0;
                fail      <= 1'b1;
                err_lanes <= mis;
                err_bits  <= err_sum;
            end
        end
    end

endmodule

// File: tb/tb_gen_pattern_checker.sv
// tb_gen_pattern_checker: directed self-checking bench for gen_pattern_checker (lane 3 on and off)
module tb_gen_pattern_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] word1 = '0, word2 = '0, word3 = '0;

    logic       busy_a, pass_a, fail_a, busy_b, pass_b, fail_b;
    logic [2:0] err_lanes_a, err_lanes_b;
    logic [3:0] err_bits_a, err_bits_b;
    logic [7:0] match_cnt_a, match_cnt_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gen_pattern_checker u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .word1(word1), .word2(word2), .word3(word3),
        .busy(busy_a), .pass(pass_a), .fail(fail_a),
        .err_lanes(err_lanes_a), .err_bits(err_bits_a), .match_cnt(match_cnt_a)
    );

    gen_pattern_checker #(.LANE3_EN(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .word1(word1), .word2(word2), .word3(word3),
        .busy(busy_b), .pass(pass_b), .fail(fail_b),
        .err_lanes(err_lanes_b), .err_bits(err_bits_b), .match_cnt(match_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // drive one cycle of inputs, clock it in, return at the following falling edge
    task automatic step(input logic s, input logic v, input logic [2:0] w1, input logic [2:0] w2,
                        input logic [2:0] w3);
        start = s;
        in_valid = v;
        word1 = w1;
        word2 = w2;
        word3 = w3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic b, input logic p, input logic f,
                         input logic [2:0] el, input logic [3:0] eb, input logic [7:0] mc);
        chk({tag, ".busy"}, 32'(busy_a), 32'(b));
        chk({tag, ".pass"}, 32'(pass_a), 32'(p));
        chk({tag, ".fail"}, 32'(fail_a), 32'(f));
        chk({tag, ".err_lanes"}, 32'(err_lanes_a), 32'(el));
        chk({tag, ".err_bits"}, 32'(err_bits_a), 32'(eb));
        chk({tag, ".match_cnt"}, 32'(match_cnt_a), 32'(mc));
    endtask

    initial begin
        // reset
        repeat (2) @(negedge clk);
        chk_a("reset", 0, 0, 0, 3'b000, 4'd0, 8'd0);
        chk("reset.b_busy", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        step(0, 1, 3'd4, 3'd2, 3'd7);
        chk_a("idle_ignores_valid", 0, 0, 0, 3'b000, 4'd0, 8'd0);

        // 8 good samples -> PASS
        step(1, 0, 3'd0, 3'd0, 3'd0);
        chk_a("start", 1, 0, 0, 3'b000, 4'd0, 8'd0);
        for (int i = 1; i <= 7; i++) begin
            step(0, 1, 3'd4, 3'd2, 3'd7);
            chk("run8.busy", 32'(busy_a), 32'd1);
            chk("run8.match_cnt", 32'(match_cnt_a), 32'(i));
        end
        step(0, 1, 3'd4, 3'd2, 3'd7);
        chk_a("pass8", 0, 1, 0, 3'b000, 4'd0, 8'd8);
        step(0, 1, 3'd0, 3'd0, 3'd0);
        chk_a("pass_sticky", 0, 1, 0, 3'b000, 4'd0, 8'd8);

        // 3 good then lane 2 off by one bit
        step(1, 0, 3'd0, 3'd0, 3'd0);
        chk_a("restart_from_pass", 1, 0, 0, 3'b000, 4'd0, 8'd0);
        repeat (3) step(0, 1, 3'd4, 3'd2, 3'd7);
        step(0, 1, 3'd4, 3'd3, 3'd7);
        chk_a("fail_lane2", 0, 0, 1, 3'b010, 4'd1, 8'd3);
        step(0, 1, 3'd4, 3'd2, 3'd7);
        chk_a("fail_sticky", 0, 0, 1, 3'b010, 4'd1, 8'd3);

        // all lanes wrong on the first sample
        step(1, 0, 3'd0, 3'd0, 3'd0);
        chk_a("restart_from_fail", 1, 0, 0, 3'b000, 4'd0, 8'd0);
        step(0, 1, 3'd0, 3'd0, 3'd0);
        chk_a("fail_all", 0, 0, 1, 3'b111, 4'd5, 8'd0);

        // lane 3 disabled: (4,2,0) passes on b, fails lane 3 on a
        step(1, 0, 3'd0, 3'd0, 3'd0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 3'd4, 3'd2, 3'd0);
            chk("nolane3.err_lanes", 32'(err_lanes_b), 32'd0);
            chk("nolane3.match_cnt", 32'(match_cnt_b), 32'(i));
        end
        chk("nolane3.pass", 32'(pass_b), 32'd1);
        chk("nolane3.busy", 32'(busy_b), 32'd0);
        chk("nolane3.fail", 32'(fail_b), 32'd0);
        chk_a("lane3_wrong", 0, 0, 1, 3'b100, 4'd3, 8'd0);
        step(1, 0, 3'd0, 3'd0, 3'd0);
        step(0, 1, 3'd7, 3'd2, 3'd5);
        chk("nolane3_fail.err_lanes", 32'(err_lanes_b), 32'b001);
        chk("nolane3_fail.err_bits", 32'(err_bits_b), 32'd2);

        // start with same-cycle sample, start+bad sample discarded
        step(1, 1, 3'd4, 3'd2, 3'd7);
        chk_a("start_with_valid", 1, 0, 0, 3'b000, 4'd0, 8'd0);
        repeat (5) step(0, 1, 3'd4, 3'd2, 3'd7);
        chk_a("five_good", 1, 0, 0, 3'b000, 4'd0, 8'd5);
        step(1, 1, 3'd0, 3'd0, 3'd0);
        chk_a("start_bad_discarded", 1, 0, 0, 3'b000, 4'd0, 8'd0);
        repeat (7) step(0, 1, 3'd4, 3'd2, 3'd7);
        chk_a("seven_after_restart", 1, 0, 0, 3'b000, 4'd0, 8'd7);
        step(0, 1, 3'd4, 3'd2, 3'd7);
        chk_a("pass_after_restart", 0, 1, 0, 3'b000, 4'd0, 8'd8);

        // async reset mid-run
        step(1, 0, 3'd0, 3'd0, 3'd0);
        repeat (5) step(0, 1, 3'd4, 3'd2, 3'd7);
        chk("pre_reset.match_cnt", 32'(match_cnt_a), 32'd5);
        in_valid = 1'b1;
        word1 = 3'd4;
        word2 = 3'd2;
        word3 = 3'd7;
        #1 rst_n = 1'b0;
        #1;
        chk_a("async_reset", 0, 0, 0, 3'b000, 4'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step(0, 1, 3'd4, 3'd2, 3'd7);
        chk_a("idle_after_reset", 0, 0, 0, 3'b000, 4'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
